irq_sequencer: RTL and testbench

//  Interrupt controller for the 5-stage pipeline. Synchronises and latches external IRQ lines and

---
 rtl/irq_sequencer.sv | 139 +++++++++++++
 tb/tb_irq_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer: synchronises and latches external IRQ lines, arbitrates them by
// fixed priority (index 0 highest), redirects the pipeline on a safe cycle and
// sequences the mret return to the interrupted code.
module irq_sequencer #(
    parameter int                NUM_IRQ    = 4,
    parameter int                XLEN       = 32,
    parameter logic [XLEN-1:0]   VEC_BASE   = 32'h0000_0100,
    parameter int                VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               global_en_i,
    input  logic               Valid_E,
    input  logic [XLEN-1:0]    PC_E,
    input  logic               PCSrc_E,
    input  logic               Stall_D,
    input  logic               mret_E,
    output logic               interrupt_o,
    output logic [XLEN-1:0]    vector_o,
    output logic               ret_o,
    output logic [XLEN-1:0]    ret_pc_o,
    output logic [XLEN-1:0]    mcause_o,
    output logic               in_service_o,
    output logic [NUM_IRQ-1:0] irq_ack_o
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;
    logic [NUM_IRQ-1:0] r_sync3;
    logic [NUM_IRQ-1:0] r_pending;
    logic [XLEN-1:0]    r_mepc;
    logic [XLEN-1:0]    r_mcause;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_req;
    logic [NUM_IRQ-1:0] w_sel_oh;
    logic [IDX_W-1:0]   w_sel;
    logic               w_safe;
    logic               w_take;
    logic               w_ret;

    // A line counts only on a synchronised low-to-high transition; level-high is ignored.
    assign w_rise = r_sync2 & ~r_sync3;
    assign w_req  = r_pending & irq_en_i;
    // A redirected or stalled Execute slot, a bubble, or an mret cannot carry the trap.
    assign w_safe = Valid_E & ~PCSrc_E & ~Stall_D & ~mret_E;

    // Fixed-priority pick: scanning downward leaves the lowest requesting index.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_sel = IDX_W'(i);
            end
        end
    end

    assign w_sel_oh = NUM_IRQ'(1) << w_sel;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and Mealy take/return pulses.
    always_comb begin
        w_state_nxt  = r_state;
        w_take       = 1'b0;
        w_ret        = 1'b0;
        in_service_o = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|w_req && global_en_i) begin
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (!global_en_i || !(|w_req)) begin
                    w_state_nxt = IDLE;
                end else if (w_safe) begin
                    w_take      = 1'b1;
                    w_state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                in_service_o = 1'b1;
                if (mret_E && !PCSrc_E) begin
                    w_ret       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Synchroniser chain, pending latch (a fresh edge beats the ack clear), trap context capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync3   <= '0;
            r_pending <= '0;
            r_mepc    <= '0;
            r_mcause  <= '0;
        end else begin
            r_sync1   <= irq_i;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_pending <= (r_pending & ~(w_take ? w_sel_oh : '0)) | w_rise;
            if (w_take) begin
                r_mepc   <= PC_E;
                r_mcause <= {1'b1, {(XLEN-1){1'b0}}} | XLEN'(w_sel);
            end
        end
    end

    assign interrupt_o = w_take;
    assign vector_o    = w_take ? (VEC_BASE + XLEN'(w_sel) * XLEN'(VEC_STRIDE)) : '0;
    assign irq_ack_o   = w_take ? w_sel_oh : '0;
    assign ret_o       = w_ret;
    assign ret_pc_o    = r_mepc;
    assign mcause_o    = r_mcause;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: take latency, priority, safe-cycle gating,
// masking, mret return and asynchronous reset.
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  irq_i;
    logic [3:0]  irq_en_i;
    logic        global_en_i;
    logic        Valid_E;
    logic [31:0] PC_E;
    logic        PCSrc_E;
    logic        Stall_D;
    logic        mret_E;
    logic        interrupt_o;
    logic [31:0] vector_o;
    logic        ret_o;
    logic [31:0] ret_pc_o;
    logic [31:0] mcause_o;
    logic        in_service_o;
    logic [3:0]  irq_ack_o;

    int n_assert = 0;
    int n_fail   = 0;

    irq_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_i        (irq_i),
        .irq_en_i     (irq_en_i),
        .global_en_i  (global_en_i),
        .Valid_E      (Valid_E),
        .PC_E         (PC_E),
        .PCSrc_E      (PCSrc_E),
        .Stall_D      (Stall_D),
        .mret_E       (mret_E),
        .interrupt_o  (interrupt_o),
        .vector_o     (vector_o),
        .ret_o        (ret_o),
        .ret_pc_o     (ret_pc_o),
        .mcause_o     (mcause_o),
        .in_service_o (in_service_o),
        .irq_ack_o    (irq_ack_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge, then let the inputs settle away from it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; irq_i = '0; irq_en_i = 4'hF; global_en_i = 1'b1;
        Valid_E = 1'b1; PC_E = 32'h40; PCSrc_E = 1'b0; Stall_D = 1'b0; mret_E = 1'b0;
        tick(2);
        #1;
        chk("rst_interrupt", {31'd0, interrupt_o}, 32'd0);
        chk("rst_vector", vector_o, 32'd0);
        chk("rst_ret", {31'd0, ret_o}, 32'd0);
        chk("rst_ret_pc", ret_pc_o, 32'd0);
        chk("rst_mcause", mcause_o, 32'd0);
        chk("rst_in_service", {31'd0, in_service_o}, 32'd0);
        chk("rst_ack", {28'd0, irq_ack_o}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // IRQ0 edge: sync, sync, pending, then PEND with a Mealy take.
        irq_i = 4'b0001;
        tick(3);
        #1 chk("t1_wait", {31'd0, interrupt_o}, 32'd0);
        tick(1);
        #1;
        chk("t1_take", {31'd0, interrupt_o}, 32'd1);
        chk("t1_vector", vector_o, 32'h100);
        chk("t1_ack", {28'd0, irq_ack_o}, 32'h1);
        tick(1);
        #1;
        chk("t1_pulse_once", {31'd0, interrupt_o}, 32'd0);
        chk("t1_in_service", {31'd0, in_service_o}, 32'd1);
        chk("t1_mcause", mcause_o, 32'h8000_0000);
        chk("t1_mepc", ret_pc_o, 32'h40);
        tick(2);
        #1 chk("t1_no_retake_level", {31'd0, interrupt_o}, 32'd0);

        // mret returns to the saved PC.
        PC_E = 32'h200; mret_E = 1'b1;
        #1;
        chk("t5_ret", {31'd0, ret_o}, 32'd1);
        chk("t5_ret_pc", ret_pc_o, 32'h40);
        chk("t5_no_int", {31'd0, interrupt_o}, 32'd0);
        tick(1);
        mret_E = 1'b0;
        #1;
        chk("t5_ret_once", {31'd0, ret_o}, 32'd0);
        chk("t5_service_drop", {31'd0, in_service_o}, 32'd0);
        irq_i = '0;
        tick(4);
        #1 chk("t1_level_no_repend", {31'd0, interrupt_o}, 32'd0);

        // IRQ1 and IRQ3 together: IRQ1 wins, IRQ3 after mret.
        PC_E = 32'h80;
        irq_i = 4'b1010;
        tick(4);
        #1;
        chk("t2_take1", {31'd0, interrupt_o}, 32'd1);
        chk("t2_vector1", vector_o, 32'h104);
        chk("t2_ack1", {28'd0, irq_ack_o}, 32'h2);
        tick(1);
        #1 chk("t2_mcause1", mcause_o, 32'h8000_0001);
        mret_E = 1'b1;
        #1 chk("t2_ret1", {31'd0, ret_o}, 32'd1);
        tick(1);
        mret_E = 1'b0;
        #1 chk("t2_idle_gap", {31'd0, interrupt_o}, 32'd0);
        tick(1);
        #1;
        chk("t2_take3", {31'd0, interrupt_o}, 32'd1);
        chk("t2_vector3", vector_o, 32'h10C);
        chk("t2_ack3", {28'd0, irq_ack_o}, 32'h8);
        tick(1);
        #1 chk("t2_mcause3", mcause_o, 32'h8000_0003);
        mret_E = 1'b1;
        tick(1);
        mret_E = 1'b0;
        irq_i = '0;
        tick(4);

        // Redirect for 2 cycles, stall for 1, then the first fully safe cycle takes.
        irq_i = 4'b0001; PCSrc_E = 1'b1; PC_E = 32'h300;
        tick(4);
        #1 chk("t3_pcsrc_a", {31'd0, interrupt_o}, 32'd0);
        tick(1);
        #1 chk("t3_pcsrc_b", {31'd0, interrupt_o}, 32'd0);
        tick(1);
        PCSrc_E = 1'b0; Stall_D = 1'b1;
        #1 chk("t3_stall", {31'd0, interrupt_o}, 32'd0);
        tick(1);
        Stall_D = 1'b0;
        #1;
        chk("t3_take", {31'd0, interrupt_o}, 32'd1);
        chk("t3_vector", vector_o, 32'h100);
        tick(1);
        #1 chk("t3_mepc", ret_pc_o, 32'h300);
        mret_E = 1'b1; PCSrc_E = 1'b1;
        #1 chk("t3_ret_blocked", {31'd0, ret_o}, 32'd0);
        tick(1);
        PCSrc_E = 1'b0;
        #1 chk("t3_ret", {31'd0, ret_o}, 32'd1);
        tick(1);
        mret_E = 1'b0;

        // Masked line stays pending and is taken once enabled, with no new edge.
        irq_en_i = 4'b1011; irq_i = 4'b0101;
        tick(6);
        #1;
        chk("t4_masked", {31'd0, interrupt_o}, 32'd0);
        chk("t4_masked_svc", {31'd0, in_service_o}, 32'd0);
        irq_en_i = 4'hF;
        tick(1);
        #1;
        chk("t4_take", {31'd0, interrupt_o}, 32'd1);
        chk("t4_vector", vector_o, 32'h108);
        chk("t4_ack", {28'd0, irq_ack_o}, 32'h4);
        tick(1);
        #1 chk("t4_service", {31'd0, in_service_o}, 32'd1);

        // Asynchronous reset in SERVICE clears everything; a later mret is ignored.
        #2 rst_n = 1'b0;
        #1;
        chk("t6_in_service", {31'd0, in_service_o}, 32'd0);
        chk("t6_ret_pc", ret_pc_o, 32'd0);
        chk("t6_mcause", mcause_o, 32'd0);
        irq_i = '0;
        tick(1);
        rst_n = 1'b1;
        mret_E = 1'b1;
        tick(1);
        #1;
        chk("t6_stray_mret", {31'd0, ret_o}, 32'd0);
        chk("t6_no_int", {31'd0, interrupt_o}, 32'd0);
        mret_E = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
